dut_pin_capture: RTL and testbench

- Input-side counterpart of the tester's forcing drivers: samples one DUT output pin back into the FPGA and judges it against an expected value.
- Pipeline: asynchronous pin → synchroniser → glitch filter → strobe-delayed capture → compare with EXPECT under MASK → fail bookkeeping.
- One instance per monitored DUT pin; the vector sequencer drives STROBE, EXPECT and MASK and reads back the results.

---
 rtl/dut_pin_capture_pkg.sv | 18 +
 rtl/dut_pin_capture_if.sv | 34 +++
 rtl/pin_sync_filter.sv | 50 +++++
 rtl/dut_pin_capture.sv | 150 +++++++++++++++
 tb/tb_dut_pin_capture.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dut_pin_capture_pkg.sv
// Shared tester constants for the pin capture path: FSM encoding, default filter
// geometry and the compare rule used at the capture instant.
package dut_pin_capture_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } cap_state_e;

    localparam int unsigned DefaultSyncStages = 2;
    localparam int unsigned DefaultFiltLen    = 3;

    // A masked capture never fails, whatever level was seen.
    function automatic logic is_mismatch(logic level, logic expect_val, logic mask);
        return ~mask & (level ^ expect_val);
    endfunction

endpackage

// File: rtl/dut_pin_capture_if.sv
// Sequencer-facing control and result bundle of one pin capture channel.
interface dut_pin_capture_if #(
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned CNT_W   = 16
) ();

    logic               strobe;
    logic [DELAY_W-1:0] delay;
    logic               expect_val;
    logic               mask;
    logic               clr;
    logic               busy;
    logic               sample_valid;
    logic               sample;
    logic               mismatch;
    logic               fail_sticky;
    logic               overrun;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   strobe_cnt;
    logic [CNT_W-1:0]   first_fail_idx;

    modport master (
        output strobe, delay, expect_val, mask, clr,
        input  busy, sample_valid, sample, mismatch, fail_sticky, overrun,
               fail_cnt, strobe_cnt, first_fail_idx
    );

    modport slave (
        input  strobe, delay, expect_val, mask, clr,
        output busy, sample_valid, sample, mismatch, fail_sticky, overrun,
               fail_cnt, strobe_cnt, first_fail_idx
    );

endinterface

// File: rtl/pin_sync_filter.sv
// Metastability chain followed by a glitch filter: the filtered level only moves after
// FILT_LEN consecutive synced samples disagree with it.
module pin_sync_filter
    import dut_pin_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages,
    parameter int unsigned FILT_LEN    = DefaultFiltLen
) (
    input  logic clk,
    input  logic rst_bar,
    input  logic pin,
    output logic filtered
);

    localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q == CntW'(FILT_LEN - 1)) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/dut_pin_capture.sv
// One monitored DUT pin: filtered level is captured DELAY cycles after an accepted
// strobe, compared against EXPECT under MASK, and fail statistics are kept.
module dut_pin_capture
    import dut_pin_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages,
    parameter int unsigned FILT_LEN    = DefaultFiltLen,
    parameter int unsigned DELAY_W     = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_bar,
    input  logic             pin,
    dut_pin_capture_if.slave bus
);

    logic filtered;

    pin_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sync_filter (
        .clk     (clk),
        .rst_bar (rst_bar),
        .pin     (pin),
        .filtered(filtered)
    );

    cap_state_e         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               exp_q, exp_d;
    logic               mask_q, mask_d;
    logic               valid_q, valid_d;
    logic               sample_q, sample_d;
    logic               mismatch_q, mismatch_d;
    logic               sticky_q, sticky_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   strobe_cnt_q, strobe_cnt_d;
    logic [CNT_W-1:0]   ffi_q, ffi_d;
    logic               capture;
    logic               miss;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        mask_d       = mask_q;
        valid_d      = 1'b0;
        sample_d     = sample_q;
        mismatch_d   = mismatch_q;
        sticky_d     = sticky_q;
        overrun_d    = overrun_q;
        fail_cnt_d   = fail_cnt_q;
        strobe_cnt_d = strobe_cnt_q;
        ffi_d        = ffi_q;
        capture      = 1'b0;
        miss         = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.strobe) begin
                    state_d      = StWait;
                    cnt_d        = bus.delay;
                    exp_d        = bus.expect_val;
                    mask_d       = bus.mask;
                    strobe_cnt_d = strobe_cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (bus.strobe) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                    capture = 1'b1;
                end
            end
        endcase

        if (capture) begin
            miss       = is_mismatch(filtered, exp_q, mask_q);
            valid_d    = 1'b1;
            sample_d   = filtered;
            mismatch_d = miss;
            if (miss) begin
                if (fail_cnt_q != '1) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                end
                sticky_d = 1'b1;
                // Strobe counter already includes this strobe; no other can be accepted meanwhile.
                if (!sticky_q) begin
                    ffi_d = strobe_cnt_q - 1'b1;
                end
            end
        end

        // Clear overrides bookkeeping but leaves the capture itself alone.
        if (bus.clr) begin
            sticky_d     = 1'b0;
            overrun_d    = 1'b0;
            fail_cnt_d   = '0;
            strobe_cnt_d = '0;
            ffi_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            exp_q        <= 1'b0;
            mask_q       <= 1'b0;
            valid_q      <= 1'b0;
            sample_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            sticky_q     <= 1'b0;
            overrun_q    <= 1'b0;
            fail_cnt_q   <= '0;
            strobe_cnt_q <= '0;
            ffi_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            mask_q       <= mask_d;
            valid_q      <= valid_d;
            sample_q     <= sample_d;
            mismatch_q   <= mismatch_d;
            sticky_q     <= sticky_d;
            overrun_q    <= overrun_d;
            fail_cnt_q   <= fail_cnt_d;
            strobe_cnt_q <= strobe_cnt_d;
            ffi_q        <= ffi_d;
        end
    end

    assign bus.busy           = (state_q == StWait);
    assign bus.sample_valid   = valid_q;
    assign bus.sample         = sample_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.fail_sticky    = sticky_q;
    assign bus.overrun        = overrun_q;
    assign bus.fail_cnt       = fail_cnt_q;
    assign bus.strobe_cnt     = strobe_cnt_q;
    assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_dut_pin_capture.sv
// Bench for dut_pin_capture: 16-bit and 4-bit counter instances share one stimulus and
// are compared every cycle against a history-based reference model.
module tb_dut_pin_capture;

    localparam int S = 2;
    localparam int F = 3;

    logic       clk = 1'b0;
    logic       rst_bar = 1'b1;
    logic       pin = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] delay = '0;
    logic       exp_v = 1'b0;
    logic       mask = 1'b0;
    logic       clr = 1'b0;

    always #5 clk = ~clk;

    dut_pin_capture_if #(.DELAY_W(8), .CNT_W(16)) bus16 ();
    dut_pin_capture_if #(.DELAY_W(8), .CNT_W(4))  bus4 ();

    assign bus16.strobe = strobe;
    assign bus16.delay = delay;
    assign bus16.expect_val = exp_v;
    assign bus16.mask = mask;
    assign bus16.clr = clr;
    assign bus4.strobe = strobe;
    assign bus4.delay = delay;
    assign bus4.expect_val = exp_v;
    assign bus4.mask = mask;
    assign bus4.clr = clr;

    dut_pin_capture #(.SYNC_STAGES(S), .FILT_LEN(F), .DELAY_W(8), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst_bar(rst_bar), .pin(pin), .bus(bus16)
    );
    dut_pin_capture #(.SYNC_STAGES(S), .FILT_LEN(F), .DELAY_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_bar(rst_bar), .pin(pin), .bus(bus4)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pin history since reset plus absolute capture-edge bookkeeping.
    bit pins[$];
    bit m_filt, m_pend, m_exp, m_mask, m_valid, m_sample, m_mis, m_sticky, m_ovr;
    int m_cap_edge, m_fail, m_sc, m_ffi;

    function automatic bit synced_at(int e);
        if (e - S < 1) return 1'b0;
        return pins[e-S-1];
    endfunction

    function automatic int sat(int v, int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int wrap(int v, int w);
        return v & ((1 << w) - 1);
    endfunction

    task automatic model_reset();
        pins.delete();
        {m_filt, m_pend, m_exp, m_mask, m_valid, m_sample, m_mis, m_sticky, m_ovr} = '0;
        m_cap_edge = 0;
        m_fail = 0;
        m_sc = 0;
        m_ffi = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(string n, int w, logic busy, logic valid, logic sample,
                             logic mis, logic sticky, logic ovr, logic [15:0] fc,
                             logic [15:0] sc, logic [15:0] ffi);
        chk({n, "_busy"}, 32'(busy), 32'(m_pend));
        chk({n, "_sample_valid"}, 32'(valid), 32'(m_valid));
        chk({n, "_sample"}, 32'(sample), 32'(m_sample));
        chk({n, "_mismatch"}, 32'(mis), 32'(m_mis));
        chk({n, "_fail_sticky"}, 32'(sticky), 32'(m_sticky));
        chk({n, "_overrun"}, 32'(ovr), 32'(m_ovr));
        chk({n, "_fail_cnt"}, 32'(fc), 32'(sat(m_fail, w)));
        chk({n, "_strobe_cnt"}, 32'(sc), 32'(wrap(m_sc, w)));
        chk({n, "_first_fail_idx"}, 32'(ffi), 32'(wrap(m_ffi, w)));
    endtask

    task automatic tick();
        int  e;
        bit  pend0;
        bit  flip;
        @(posedge clk);
        if (!rst_bar) begin
            model_reset();
        end else begin
            e = pins.size() + 1;
            pend0 = m_pend;
            m_valid = 1'b0;
            if (pend0 && e == m_cap_edge) begin
                m_pend = 1'b0;
                m_valid = 1'b1;
                m_sample = m_filt;
                m_mis = !m_mask && (m_filt != m_exp);
                if (m_mis) begin
                    m_fail++;
                    if (!m_sticky) m_ffi = m_sc - 1;
                    m_sticky = 1'b1;
                end
            end
            if (pend0 && strobe) m_ovr = 1'b1;
            if (!pend0 && strobe) begin
                m_pend = 1'b1;
                m_cap_edge = e + 1 + int'(delay);
                m_exp = exp_v;
                m_mask = mask;
                m_sc++;
            end
            // Level moves once the last F synced samples all disagree with it.
            flip = 1'b1;
            for (int k = 0; k < F; k++) begin
                if (synced_at(e - k) == m_filt) flip = 1'b0;
            end
            if (flip) m_filt = ~m_filt;
            pins.push_back(pin);
            if (clr) begin
                m_sticky = 1'b0;
                m_ovr = 1'b0;
                m_fail = 0;
                m_sc = 0;
                m_ffi = 0;
            end
        end
        #1;
        check_dut("d16", 16, bus16.busy, bus16.sample_valid, bus16.sample, bus16.mismatch,
                  bus16.fail_sticky, bus16.overrun, bus16.fail_cnt, bus16.strobe_cnt,
                  bus16.first_fail_idx);
        check_dut("d4", 4, bus4.busy, bus4.sample_valid, bus4.sample, bus4.mismatch,
                  bus4.fail_sticky, bus4.overrun, 16'(bus4.fail_cnt), 16'(bus4.strobe_cnt),
                  16'(bus4.first_fail_idx));
    endtask

    initial begin
        model_reset();
        #2 rst_bar = 1'b0;
        repeat (3) tick();
        pin = 1'b1;
        rst_bar = 1'b1;

        // Stable high pin, DELAY=0 capture.
        repeat (9) tick();
        strobe = 1'b1; delay = 8'd0; exp_v = 1'b1; mask = 1'b0;
        tick();
        strobe = 1'b0;
        chk("tp1_busy", 32'(bus16.busy), 32'd1);
        tick();
        chk("tp1_valid", 32'(bus16.sample_valid), 32'd1);
        chk("tp1_sample", 32'(bus16.sample), 32'd1);
        chk("tp1_mismatch", 32'(bus16.mismatch), 32'd0);
        chk("tp1_strobe_cnt", 32'(bus16.strobe_cnt), 32'd1);
        tick();

        // Single-cycle glitch must not reach the capture.
        pin = 1'b0;
        repeat (8) tick();
        pin = 1'b1; strobe = 1'b1; delay = 8'd2; exp_v = 1'b0;
        tick();
        pin = 1'b0; strobe = 1'b0;
        repeat (4) tick();
        chk("glitch_sample", 32'(bus16.sample), 32'd0);
        chk("glitch_mismatch", 32'(bus16.mismatch), 32'd0);

        // Three back-to-back mismatching strobes, DELAY=5.
        pin = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (6) tick();
        delay = 8'd5; exp_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            repeat (6) tick();
            chk("b2b_valid", 32'(bus16.sample_valid), 32'd1);
        end
        tick();
        chk("b2b_fail_cnt", 32'(bus16.fail_cnt), 32'd3);
        chk("b2b_sticky", 32'(bus16.fail_sticky), 32'd1);
        chk("b2b_ffi", 32'(bus16.first_fail_idx), 32'd0);

        // Strobe while busy is dropped and flagged.
        clr = 1'b1;
        tick();
        clr = 1'b0; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (8) tick();
        chk("ovr_overrun", 32'(bus16.overrun), 32'd1);
        chk("ovr_strobe_cnt", 32'(bus16.strobe_cnt), 32'd1);

        // Saturation on the narrow instance, wrap of its strobe counter.
        clr = 1'b1; delay = 8'd0;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            tick();
        end
        tick();
        chk("sat_fail_cnt4", 32'(bus4.fail_cnt), 32'd15);
        chk("sat_strobe_cnt4", 32'(bus4.strobe_cnt), 32'd4);
        chk("sat_fail_cnt16", 32'(bus16.fail_cnt), 32'd20);

        // Clear coincident with a mismatching capture.
        strobe = 1'b1; delay = 8'd2;
        tick();
        strobe = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_valid", 32'(bus16.sample_valid), 32'd1);
        chk("clr_fail_cnt", 32'(bus16.fail_cnt), 32'd0);
        chk("clr_sticky", 32'(bus16.fail_sticky), 32'd0);

        // Reset in the middle of a wait abandons the capture.
        strobe = 1'b1; delay = 8'd10;
        tick();
        strobe = 1'b0;
        repeat (3) tick();
        rst_bar = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(bus16.busy), 32'd0);
        chk("rst_sample", 32'(bus16.sample), 32'd0);
        rst_bar = 1'b1;
        repeat (15) tick();

        // Random pin activity, strobes, masks, delays and occasional clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pin = ~pin;
            strobe = ($urandom_range(0, 3) == 0);
            delay = 8'($urandom_range(0, 6));
            exp_v = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            tick();
        end
        strobe = 1'b0; clr = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
